// File: rtl/reg_bank_seq.sv
// Host-written register bank with a block engine (SUM / MAX / COPY / CLEAR over an index range).
// Latency: read_data is combinational; a block operation stays busy for LEN+1 cycles including the done cycle.
// Backpressure: none; host writes arriving while busy are dropped and flagged on write_err.
//
// Ports:
//   clk, reset     - single clock, asynchronous active-high reset
//   write_en/addr/data/strb - host write port, byte strobed, word-aligned index in addr[IDX_W+1:2]
//   read_addr, read_data    - combinational read port, same index decode as the write port
//   busy, done, write_err   - engine active, end-of-operation pulse, rejected-write pulse
module reg_bank_seq #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_en,
    input  logic [ADDR_W-1:0]     write_addr,
    input  logic [DATA_W-1:0]     write_data,
    input  logic [DATA_W/8-1:0]   write_strb,
    input  logic [ADDR_W-1:0]     read_addr,
    output logic [DATA_W-1:0]     read_data,
    output logic                  busy,
    output logic                  done,
    output logic                  write_err
);

    localparam int IDX_W  = $clog2(NUM_REGS);
    localparam int STRB_W = DATA_W / 8;

    localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(0);
    localparam logic [IDX_W-1:0] IDX_SRC    = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LEN    = IDX_W'(2);
    localparam logic [IDX_W-1:0] IDX_DST    = IDX_W'(3);
    localparam logic [IDX_W-1:0] IDX_RESULT = IDX_W'(4);
    localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(5);
    // First index the engine may write; everything below is control/status.
    localparam logic [IDX_W-1:0] IDX_DATA0  = IDX_W'(6);

    localparam logic [IDX_W:0]   LEN_MAX    = (IDX_W+1)'(NUM_REGS);
    localparam logic [IDX_W:0]   CNT_ZERO   = '0;
    localparam logic [IDX_W:0]   CNT_ONE    = (IDX_W+1)'(1);

    localparam logic [1:0] OP_SUM   = 2'd0;
    localparam logic [1:0] OP_MAX   = 2'd1;
    localparam logic [1:0] OP_COPY  = 2'd2;
    localparam logic [1:0] OP_CLEAR = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FINISH
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] view   [NUM_REGS];

    state_t            state_q;
    logic              busy_q;
    logic              done_q;
    logic              write_err_q;
    logic              err_sticky_q;
    logic [IDX_W-1:0]  src_q;
    logic [IDX_W-1:0]  dst_q;
    logic [IDX_W:0]    len_q;
    logic [IDX_W:0]    cnt_q;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] acc_q;

    // ------------------------------------------------------------------
    // Register view: what the host and the engine both see on a read.
    // STATUS is synthesised from live state rather than stored.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] status_word;

    always_comb begin
        status_word    = '0;
        status_word[0] = busy_q;
        status_word[1] = err_sticky_q;
    end

    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            view[i] = regs_q[i];
        end
        view[IDX_STATUS] = status_word;
    end

    logic [IDX_W-1:0] rd_idx;
    assign rd_idx    = read_addr[IDX_W+1:2];
    assign read_data = view[rd_idx];

    // Upper address bits alias onto the register file; byte-offset bits are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{write_addr[ADDR_W-1:IDX_W+2], write_addr[1:0],
                                read_addr[ADDR_W-1:IDX_W+2], read_addr[1:0]};

    // ------------------------------------------------------------------
    // Host write decode
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]  wr_idx;
    logic [DATA_W-1:0] wr_merged;
    logic [DATA_W-1:0] wr_val;
    logic              host_wr;
    logic              host_reject;
    logic              wr_to_ro;
    logic              start_req;
    logic              start_bad;
    logic              start_ok;
    logic [IDX_W:0]    len_reg;

    assign wr_idx      = write_addr[IDX_W+1:2];
    assign host_wr     = write_en && !busy_q;
    assign host_reject = write_en && busy_q;
    assign wr_to_ro    = (wr_idx == IDX_RESULT) || (wr_idx == IDX_STATUS);
    assign len_reg     = regs_q[IDX_LEN][IDX_W:0];

    always_comb begin
        wr_merged = regs_q[wr_idx];
        for (int b = 0; b < STRB_W; b++) begin
            if (write_strb[b]) begin
                wr_merged[b*8 +: 8] = write_data[b*8 +: 8];
            end
        end
        // start is a command bit, never stored
        wr_val = wr_merged;
        if (wr_idx == IDX_CTRL) begin
            wr_val[3] = 1'b0;
        end
    end

    // The start bit lives in byte 0, so it only counts when that byte is strobed.
    assign start_req = host_wr && (wr_idx == IDX_CTRL) && write_strb[0] && write_data[3];
    // Ops 4-7 all have bit 2 set.
    assign start_bad = start_req && (wr_merged[2] || (len_reg > LEN_MAX));
    assign start_ok  = start_req && !start_bad;

    // ------------------------------------------------------------------
    // Engine datapath (meaningful only in ST_RUN)
    // ------------------------------------------------------------------
    logic              in_run;
    logic [IDX_W-1:0]  src_idx;
    logic [IDX_W-1:0]  dst_idx;
    logic [DATA_W-1:0] eng_val;
    logic [DATA_W-1:0] acc_nxt;
    logic              last_elem;
    logic              eng_move;
    logic              eng_wr_ok;
    logic              eng_wr_blocked;
    logic [DATA_W-1:0] eng_wr_dat;
    logic              res_wr;
    logic [DATA_W-1:0] res_dat;

    assign in_run    = (state_q == ST_RUN);
    // IDX_W-bit adds wrap modulo NUM_REGS for free.
    assign src_idx   = src_q + cnt_q[IDX_W-1:0];
    assign dst_idx   = dst_q + cnt_q[IDX_W-1:0];
    assign eng_val   = view[src_idx];
    assign last_elem = (cnt_q == (len_q - CNT_ONE));

    always_comb begin
        acc_nxt = acc_q;
        case (op_q)
            OP_SUM:  acc_nxt = acc_q + eng_val;
            OP_MAX:  acc_nxt = (eng_val > acc_q) ? eng_val : acc_q;
            default: acc_nxt = acc_q;
        endcase
    end

    assign eng_move       = in_run && ((op_q == OP_COPY) || (op_q == OP_CLEAR));
    assign eng_wr_ok      = eng_move && (dst_idx >= IDX_DATA0);
    assign eng_wr_blocked = eng_move && (dst_idx < IDX_DATA0);
    assign eng_wr_dat     = (op_q == OP_COPY) ? eng_val : '0;

    // RESULT is written on the last RUN edge, or on the start edge of a zero-length SUM/MAX.
    // Legal ops 0/1 are the reductions, i.e. bit 1 clear.
    always_comb begin
        res_wr  = 1'b0;
        res_dat = '0;
        if (in_run && last_elem && !op_q[1]) begin
            res_wr  = 1'b1;
            res_dat = acc_nxt;
        end else if (start_ok && (len_reg == CNT_ZERO) && !wr_merged[1]) begin
            res_wr  = 1'b1;
            res_dat = '0;
        end
    end

    // ------------------------------------------------------------------
    // Register file, sticky error and write_err pulse.
    // Host writes and engine writes are mutually exclusive: host writes
    // only land while idle, the engine only writes in RUN.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            err_sticky_q <= 1'b0;
            write_err_q  <= 1'b0;
        end else begin
            write_err_q <= host_reject || start_bad;

            if (host_wr && !wr_to_ro) begin
                regs_q[wr_idx] <= wr_val;
            end
            if (eng_wr_ok) begin
                regs_q[dst_idx] <= eng_wr_dat;
            end
            if (res_wr) begin
                regs_q[IDX_RESULT] <= res_dat;
            end

            if (start_ok) begin
                err_sticky_q <= 1'b0;
            end else if (host_reject || start_bad || eng_wr_blocked) begin
                err_sticky_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Engine FSM with registered busy/done
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            op_q    <= OP_SUM;
            acc_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start_ok) begin
                        src_q  <= regs_q[IDX_SRC][IDX_W-1:0];
                        dst_q  <= regs_q[IDX_DST][IDX_W-1:0];
                        len_q  <= len_reg;
                        op_q   <= wr_merged[1:0];
                        cnt_q  <= '0;
                        acc_q  <= '0;
                        busy_q <= 1'b1;
                        if (len_reg == CNT_ZERO) begin
                            state_q <= ST_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_nxt;
                    cnt_q <= cnt_q + CNT_ONE;
                    if (last_elem) begin
                        state_q <= ST_FINISH;
                        done_q  <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign write_err = write_err_q;

endmodule
